wb_soc_xbar: RTL

- Parametrised Wishbone interconnect for the FazyRV SoC family.
- Arbitrates the core's instruction and data masters onto NSLV slaves (QSPI memory, register file, SPI, future peripherals).
- Registered grant with round-robin fairness; per-slave fetch permission; unmapped-address and timeout bus errors; saturating error counter.

---
 rtl/wb_soc_xbar.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/wb_soc_xbar.sv
// rtl/wb_soc_xbar.sv - Wishbone crossbar: imem/dmem masters onto NSLV slaves
// Registered round-robin grant, fetch permission, unmapped/timeout errors, error counter.
module wb_soc_xbar #(
  parameter int                         NSLV        = 4,
  parameter int                         REGION_LSB  = 28,
  parameter int                         REGION_W    = 3,
  parameter logic [NSLV*REGION_W-1:0]   SLV_MAP     = {3'd4, 3'd2, 3'd1, 3'd0},
  parameter logic [NSLV-1:0]            IFETCH_MASK = 4'b0011,
  parameter int                         TIMEOUT     = 255
) (
  input  logic               clk_i,
  input  logic               rst_in,
  input  logic               wb_imem_stb_i,
  input  logic [31:0]        wb_imem_adr_i,
  output logic [31:0]        wb_imem_dat_o,
  output logic               wb_imem_ack_o,
  output logic               wb_imem_err_o,
  input  logic               wb_dmem_stb_i,
  input  logic               wb_dmem_we_i,
  input  logic [3:0]         wb_dmem_be_i,
  input  logic [31:0]        wb_dmem_adr_i,
  input  logic [31:0]        wb_dmem_dat_i,
  output logic [31:0]        wb_dmem_dat_o,
  output logic               wb_dmem_ack_o,
  output logic               wb_dmem_err_o,
  output logic [NSLV-1:0]    wb_s_stb_o,
  output logic               wb_s_we_o,
  output logic [3:0]         wb_s_be_o,
  output logic [31:0]        wb_s_adr_o,
  output logic [31:0]        wb_s_dat_o,
  input  logic [NSLV*32-1:0] wb_s_dat_i,
  input  logic [NSLV-1:0]    wb_s_ack_i,
  output logic [7:0]         err_cnt_o
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, ERR} state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_gnt_d;
  logic                r_last_d;
  logic [SW-1:0]       r_sel;
  logic [TW-1:0]       r_tcnt;
  logic [7:0]          r_err_cnt;

  logic                w_req;
  logic                w_both;
  logic                w_pick_d;
  logic [REGION_W-1:0] w_region;
  logic                w_hit;
  logic [SW-1:0]       w_idx;
  logic [31:0]         w_sdat;
  logic                w_sack;
  logic                w_mstb;
  logic                w_ack;
  logic                w_tmo;

  // Contention goes to the master that did not win the previous contention.
  always_comb begin
    w_req    = wb_imem_stb_i || wb_dmem_stb_i;
    w_both   = wb_imem_stb_i && wb_dmem_stb_i;
    w_pick_d = wb_dmem_stb_i && (!wb_imem_stb_i || !r_last_d);
    w_region = w_pick_d ? wb_dmem_adr_i[REGION_LSB +: REGION_W]
                        : wb_imem_adr_i[REGION_LSB +: REGION_W];
    w_hit    = 1'b0;
    w_idx    = '0;
    // Scan downward so the lowest matching slave is the one left standing.
    for (int k = NSLV - 1; k >= 0; k--) begin
      if (SLV_MAP[k*REGION_W +: REGION_W] == w_region) begin
        w_hit = w_pick_d || IFETCH_MASK[k];
        w_idx = SW'(k);
      end
    end
  end

  always_comb begin
    w_sdat = '0;
    w_sack = 1'b0;
    for (int k = 0; k < NSLV; k++) begin
      if (r_sel == SW'(k)) begin
        w_sdat = wb_s_dat_i[k*32 +: 32];
        w_sack = wb_s_ack_i[k];
      end
    end
  end

  assign w_mstb = ((r_state == GNT_I) && wb_imem_stb_i) ||
                  ((r_state == GNT_D) && wb_dmem_stb_i);
  assign w_ack  = w_mstb && w_sack;
  assign w_tmo  = (TIMEOUT != 0) && (r_tcnt == TLAST);

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (!w_hit)        w_next = ERR;
          else if (w_pick_d) w_next = GNT_D;
          else               w_next = GNT_I;
        end
      end
      GNT_I, GNT_D: begin
        if (!w_mstb || w_ack) w_next = IDLE;
        else if (w_tmo)       w_next = ERR;
      end
      ERR:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_in) begin
      r_state   <= IDLE;
      r_gnt_d   <= 1'b0;
      r_last_d  <= 1'b0;
      r_sel     <= '0;
      r_tcnt    <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_req) begin
        r_gnt_d <= w_pick_d;
        r_sel   <= w_idx;
        if (w_both) r_last_d <= w_pick_d;
      end
      if (r_state == IDLE)      r_tcnt <= '0;
      else if (w_mstb && !w_ack) r_tcnt <= r_tcnt + TW'(1);
      if (w_next == ERR && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  always_comb begin
    for (int k = 0; k < NSLV; k++) begin
      wb_s_stb_o[k] = w_mstb && (r_sel == SW'(k));
    end
  end

  assign wb_s_adr_o    = r_gnt_d ? wb_dmem_adr_i : wb_imem_adr_i;
  assign wb_s_we_o     = r_gnt_d && wb_dmem_we_i;
  assign wb_s_be_o     = r_gnt_d ? wb_dmem_be_i : 4'hF;
  assign wb_s_dat_o    = r_gnt_d ? wb_dmem_dat_i : 32'h0;

  assign wb_imem_ack_o = rst_in && w_ack && (r_state == GNT_I);
  assign wb_dmem_ack_o = rst_in && w_ack && (r_state == GNT_D);
  assign wb_imem_err_o = rst_in && (r_state == ERR) && !r_gnt_d;
  assign wb_dmem_err_o = rst_in && (r_state == ERR) && r_gnt_d;
  assign wb_imem_dat_o = (r_state == GNT_I) ? w_sdat : 32'h0;
  assign wb_dmem_dat_o = (r_state == GNT_D) ? w_sdat : 32'h0;
  assign err_cnt_o     = r_err_cnt;

endmodule
